spi_slave_sync: RTL and testbench

- Parametrised successor to the team's mode-0 byte SPI slave.
- Runs entirely in the FPGA clock domain: SCLK, MOSI and CS_n are oversampled through synchronisers, and SCLK edges are detected in i_Clk. No logic is clocked by SCLK.
- Supports all four SPI modes, configurable word width, MSB/LSB-first ordering, multi-word transactions, and a ready/valid TX holding register with underrun and partial-word flags.
- Sits between an external SPI master and fabric register/stream logic.

---
 rtl/spi_slave_sync.sv | 174 +++++++++++++++++
 tb/tb_spi_slave_sync.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled entirely in the i_Clk domain: all four SPI modes, parametric word width
// and bit order, multi-word transactions and a ready/valid TX holding register.
module spi_slave_sync #(
    parameter int SPI_MODE    = 0,
    parameter int WORD_W      = 8,
    parameter int LSB_FIRST   = 0,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_TX_Valid,
    input  logic [WORD_W-1:0] i_TX_Word,
    output logic              o_TX_Ready,
    output logic              o_TX_Underrun,
    output logic              o_RX_DV,
    output logic [WORD_W-1:0] o_RX_Word,
    output logic              o_RX_Partial,
    output logic              o_Busy,
    output logic [CNT_W-1:0]  o_Word_Count,
    input  logic              i_SPI_Clk,
    input  logic              i_SPI_MOSI,
    input  logic              i_SPI_CS_n,
    output logic              o_SPI_MISO
);

    localparam logic CPOL = 1'((SPI_MODE >> 1) & 1);
    localparam logic CPHA = 1'(SPI_MODE & 1);
    localparam int BIT_W = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic                   sclk_prev;
    logic                   csn_prev;

    logic                   busy;
    logic [BIT_W-1:0]       bit_cnt;
    logic [WORD_W-1:0]      rx_shift;
    logic [WORD_W-1:0]      rx_next;
    logic [WORD_W-1:0]      rx_word;
    logic                   rx_dv;
    logic                   rx_partial;
    logic [CNT_W-1:0]       word_cnt;

    logic [WORD_W-1:0]      tx_shift;
    logic [WORD_W-1:0]      hold_data;
    logic                   hold_full;

    logic sclk_s, mosi_s, csn_s;
    logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_start, cs_stop;
    logic load, shift, tx_accept;
    logic [WORD_W-1:0] load_word;
    logic miso_bit;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];

    // CS_n chain resets low so a start needs CS_n seen high after reset first.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            mosi_sync <= '0;
            csn_sync  <= '0;
            sclk_prev <= CPOL;
            csn_prev  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], i_SPI_CS_n};
            sclk_prev <= sclk_s;
            csn_prev  <= csn_s;
        end
    end

    assign sclk_edge   = busy && !csn_s && (sclk_s != sclk_prev);
    assign lead_edge   = sclk_edge && (sclk_s != CPOL);
    assign trail_edge  = sclk_edge && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_start    = csn_prev && !csn_s;
    assign cs_stop     = busy && csn_s;

    // A shift edge with bit_cnt at zero always presents bit 0 of a fresh word.
    assign load      = (cs_start && !CPHA) || (shift_edge && (bit_cnt == '0));
    assign shift     = shift_edge && (bit_cnt != '0);
    assign load_word = hold_full ? hold_data : '0;
    assign tx_accept = i_TX_Valid && !hold_full;

    always_comb begin
        rx_next = rx_shift;
        if (LSB_FIRST != 0) begin
            rx_next = {mosi_s, rx_shift[WORD_W-1:1]};
        end else begin
            rx_next = {rx_shift[WORD_W-2:0], mosi_s};
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            busy       <= 1'b0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            rx_word    <= '0;
            rx_dv      <= 1'b0;
            rx_partial <= 1'b0;
            word_cnt   <= '0;
        end else begin
            rx_dv      <= 1'b0;
            rx_partial <= 1'b0;
            if (cs_start) begin
                busy     <= 1'b1;
                bit_cnt  <= '0;
                word_cnt <= '0;
                rx_shift <= '0;
            end else if (cs_stop) begin
                busy       <= 1'b0;
                bit_cnt    <= '0;
                rx_shift   <= '0;
                rx_partial <= (bit_cnt != '0);
            end else if (sample_edge) begin
                rx_shift <= rx_next;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    rx_word <= rx_next;
                    rx_dv   <= 1'b1;
                    if (word_cnt != {CNT_W{1'b1}}) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // A write coinciding with a load into an empty register is kept for the next slot.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            tx_shift  <= '0;
        end else begin
            if (load) begin
                hold_full <= tx_accept;
            end else if (tx_accept) begin
                hold_full <= 1'b1;
            end
            if (tx_accept) begin
                hold_data <= i_TX_Word;
            end
            if (load) begin
                tx_shift <= load_word;
            end else if (shift) begin
                tx_shift <= (LSB_FIRST != 0) ? (tx_shift >> 1) : (tx_shift << 1);
            end
        end
    end

    assign miso_bit = (LSB_FIRST != 0) ? tx_shift[0] : tx_shift[WORD_W-1];
    assign o_SPI_MISO = i_SPI_CS_n ? 1'bz : miso_bit;

    assign o_TX_Ready    = !hold_full;
    assign o_TX_Underrun = load && !hold_full;
    assign o_RX_DV       = rx_dv;
    assign o_RX_Word     = rx_word;
    assign o_RX_Partial  = rx_partial;
    assign o_Busy        = busy;
    assign o_Word_Count  = word_cnt;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: five instances covering all SPI modes plus a 16-bit LSB-first build,
// driven by a bit-level SPI master and checked against a word-level transaction model.
module tb_spi_slave_sync;
  localparam int NI   = 5;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        spi_clk  [NI];
  logic        spi_mosi [NI];
  logic        spi_csn  [NI];
  logic        tx_valid [NI];
  logic [31:0] tx_word  [NI];
  wire         tx_ready_a [NI];
  wire         underrun_a [NI];
  wire         rx_dv_a    [NI];
  wire         partial_a  [NI];
  wire         busy_a     [NI];
  wire         miso_a     [NI];
  wire  [31:0] rx_word_a  [NI];
  wire  [7:0]  wcnt_a     [NI];

  int n_checks = 0;
  int n_fail   = 0;
  int dv_cnt    [NI];
  int under_cnt [NI];
  int part_cnt  [NI];
  int under_snap;
  logic [31:0] exp_q[$];

  function automatic int cfg_mode(int idx); return (idx < 4) ? idx : 1; endfunction
  function automatic int cfg_w(int idx); return (idx < 4) ? 8 : 16; endfunction
  function automatic bit cfg_lsb(int idx); return idx == 4; endfunction
  function automatic logic [31:0] wmask(int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      localparam int W = (g < 4) ? 8 : 16;
      wire [W-1:0] rxw;
      wire [7:0]   wc;
      wire         rdy, und, dv, part, bsy;
      wire         miso_w;
      pullup (miso_w);
      spi_slave_sync #(
        .SPI_MODE((g < 4) ? g : 1), .WORD_W(W), .LSB_FIRST((g == 4) ? 1 : 0),
        .SYNC_STAGES((g == 4) ? 3 : 2), .CNT_W(8)
      ) u_dut (
        .i_Clk(clk), .i_Rst_L(rst_n),
        .i_TX_Valid(tx_valid[g]), .i_TX_Word(tx_word[g][W-1:0]),
        .o_TX_Ready(rdy), .o_TX_Underrun(und),
        .o_RX_DV(dv), .o_RX_Word(rxw), .o_RX_Partial(part),
        .o_Busy(bsy), .o_Word_Count(wc),
        .i_SPI_Clk(spi_clk[g]), .i_SPI_MOSI(spi_mosi[g]), .i_SPI_CS_n(spi_csn[g]),
        .o_SPI_MISO(miso_w)
      );
      assign tx_ready_a[g] = rdy;
      assign underrun_a[g] = und;
      assign rx_dv_a[g]    = dv;
      assign partial_a[g]  = part;
      assign busy_a[g]     = bsy;
      assign miso_a[g]     = miso_w;
      assign rx_word_a[g]  = 32'(rxw);
      assign wcnt_a[g]     = wc;
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: every RX word and every pulse is observed here
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rx_dv_a[i] === 1'b1) begin
        dv_cnt[i]++;
        if (exp_q.size() == 0) check_eq("rx_dv_unexpected", 32'(exp_q.size() != 0), 32'd1);
        else check_eq("rx_word", rx_word_a[i], exp_q.pop_front());
      end
      if (underrun_a[i] === 1'b1) under_cnt[i]++;
      if (partial_a[i] === 1'b1) part_cnt[i]++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input int idx, input logic [31:0] w);
    int n;
    n = 0;
    tx_word[idx]  = w;
    tx_valid[idx] = 1'b1;
    while (tx_ready_a[idx] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("offer_ready", 32'(tx_ready_a[idx]), 32'd1);
    @(negedge clk);
    tx_valid[idx] = 1'b0;
  endtask

  task automatic cs_begin(input int idx);
    spi_csn[idx] = 1'b0;
    wait_clks(12);
  endtask

  task automatic cs_end(input int idx);
    wait_clks(HALF);
    spi_csn[idx] = 1'b1;
    wait_clks(12);
  endtask

  // master side: bit k of the word is the k-th bit on the wire in the instance's order
  task automatic spi_bits(input int idx, input int nbits, input logic [31:0] v, output logic [31:0] m);
    int  w, bi;
    bit  cpol, cpha, lsb;
    w    = cfg_w(idx);
    cpol = (cfg_mode(idx) / 2) == 1;
    cpha = (cfg_mode(idx) % 2) == 1;
    lsb  = cfg_lsb(idx);
    m    = '0;
    for (int k = 0; k < nbits; k++) begin
      bi = lsb ? k : (w - 1 - k);
      if (!cpha) begin
        spi_mosi[idx] = v[bi];
        wait_clks(HALF);
        m[bi] = miso_a[idx];
        spi_clk[idx] = ~cpol;
        wait_clks(HALF);
        if (k == nbits - 1) under_snap = under_cnt[idx];
        spi_clk[idx] = cpol;
      end else begin
        spi_clk[idx]  = ~cpol;
        spi_mosi[idx] = v[bi];
        wait_clks(HALF);
        m[bi] = miso_a[idx];
        spi_clk[idx] = cpol;
        wait_clks(HALF);
      end
    end
  endtask

  // Transaction model: loads = words (+1 trailing load when CPHA=0); load j sends offer j or zeros.
  task automatic run_txn(input int idx, input int nwords, input logic [31:0] offers[$],
                         input logic [31:0] mosi_w[$]);
    int w, loads, u0, d0, p0;
    logic [31:0] got[$];
    logic [31:0] m, ex;
    w     = cfg_w(idx);
    loads = nwords + (((cfg_mode(idx) % 2) == 0) ? 1 : 0);
    u0 = under_cnt[idx]; d0 = dv_cnt[idx]; p0 = part_cnt[idx];
    if (offers.size() > 0) offer(idx, offers[0]);
    for (int j = 0; j < nwords; j++) exp_q.push_back(mosi_w[j] & wmask(w));
    cs_begin(idx);
    check_eq("busy_in_txn", 32'(busy_a[idx]), 32'd1);
    fork
      begin
        for (int j = 1; j < offers.size(); j++) offer(idx, offers[j]);
      end
      begin
        for (int j = 0; j < nwords; j++) begin
          spi_bits(idx, w, mosi_w[j], m);
          got.push_back(m);
        end
      end
    join
    cs_end(idx);
    for (int j = 0; j < nwords; j++) begin
      ex = (j < offers.size()) ? (offers[j] & wmask(w)) : 32'd0;
      check_eq("miso_word", got[j], ex);
    end
    check_eq("underruns", 32'(under_cnt[idx] - u0), 32'(loads - offers.size()));
    check_eq("rx_dv_count", 32'(dv_cnt[idx] - d0), 32'(nwords));
    check_eq("no_partial", 32'(part_cnt[idx] - p0), 32'd0);
    check_eq("word_count", 32'(wcnt_a[idx]), 32'(nwords));
    check_eq("busy_after", 32'(busy_a[idx]), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag, input int idx);
    check_eq({tag, "_ready"}, 32'(tx_ready_a[idx]), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy_a[idx]), 32'd0);
    check_eq({tag, "_wcnt"}, 32'(wcnt_a[idx]), 32'd0);
    check_eq({tag, "_rxword"}, rx_word_a[idx], 32'd0);
    check_eq({tag, "_pulses"}, 32'({rx_dv_a[idx], partial_a[idx], underrun_a[idx]}), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q_off[$];
    logic [31:0] q_mosi[$];
    logic [31:0] m0, m1, m;
    int u0, d0, p0, idx, nw, no;
    bit found;

    for (int i = 0; i < NI; i++) begin
      spi_clk[i] = (cfg_mode(i) >= 2); spi_mosi[i] = 1'b0; spi_csn[i] = 1'b1;
      tx_valid[i] = 1'b0; tx_word[i] = '0;
      dv_cnt[i] = 0; under_cnt[i] = 0; part_cnt[i] = 0;
    end
    under_snap = 0;
    rst_n = 1'b0;
    wait_clks(5);
    for (int i = 0; i < NI; i++) begin
      check_reset_vals("rst", i);
      check_eq("rst_miso_z", 32'(miso_a[i]), 32'd1);
    end
    rst_n = 1'b1;
    wait_clks(5);

    // mode 0, holding A5, master sends 3C; no underrun inside the word
    u0 = under_cnt[0];
    q_off = {}; q_off.push_back(32'hA5);
    q_mosi = {}; q_mosi.push_back(32'h3C);
    run_txn(0, 1, q_off, q_mosi);
    check_eq("t1_no_underrun_in_word", 32'(under_snap - u0), 32'd0);

    // modes 1..3
    for (int i = 1; i < 4; i++) begin
      q_off = {}; q_off.push_back(32'h5A);
      q_mosi = {}; q_mosi.push_back(32'hC3);
      run_txn(i, 1, q_off, q_mosi);
    end

    // 16-bit LSB-first burst of three with two offered words
    q_off = {}; q_off.push_back(32'h1234); q_off.push_back(32'hBEEF);
    q_mosi = {};
    for (int j = 0; j < 3; j++) q_mosi.push_back($urandom & 32'hFFFF);
    run_txn(4, 3, q_off, q_mosi);

    // CS released after 5 bits
    u0 = under_cnt[0]; d0 = dv_cnt[0]; p0 = part_cnt[0];
    offer(0, 32'h5C);
    cs_begin(0);
    spi_bits(0, 5, 32'h000000E7, m);
    cs_end(0);
    check_eq("t4_miso_bits", m & 32'hF8, 32'h58);
    check_eq("t4_partial", 32'(part_cnt[0] - p0), 32'd1);
    check_eq("t4_no_dv", 32'(dv_cnt[0] - d0), 32'd0);
    check_eq("t4_no_underrun", 32'(under_cnt[0] - u0), 32'd0);
    check_eq("t4_busy", 32'(busy_a[0]), 32'd0);
    check_eq("t4_wcnt_hold", 32'(wcnt_a[0]), 32'd0);
    q_off = {}; q_off.push_back(32'h3A);
    q_mosi = {}; q_mosi.push_back(32'h96);
    run_txn(0, 1, q_off, q_mosi);

    // write coinciding with an underrunning load
    u0 = under_cnt[0]; d0 = dv_cnt[0];
    m0 = $urandom & 32'hFF; m1 = $urandom & 32'hFF;
    exp_q.push_back(m0); exp_q.push_back(m1);
    spi_csn[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (underrun_a[0] === 1'b1) begin
        tx_word[0] = 32'h6B; tx_valid[0] = 1'b1; found = 1'b1;
      end
    end
    check_eq("t5_load_seen", 32'(found), 32'd1);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    check_eq("t5_ready_low", 32'(tx_ready_a[0]), 32'd0);
    check_eq("t5_underrun_pulse", 32'(under_cnt[0] - u0), 32'd1);
    wait_clks(8);
    spi_bits(0, 8, m0, m);
    check_eq("t5_word0_zero", m, 32'h00);
    spi_bits(0, 8, m1, m);
    check_eq("t5_word1_retained", m, 32'h6B);
    cs_end(0);
    check_eq("t5_underruns", 32'(under_cnt[0] - u0), 32'd2);
    check_eq("t5_dv", 32'(dv_cnt[0] - d0), 32'd2);

    // reset mid-word on mode 3
    d0 = dv_cnt[3];
    offer(3, 32'h77);
    cs_begin(3);
    spi_bits(3, 3, 32'hFF, m);
    rst_n = 1'b0;
    wait_clks(2);
    check_reset_vals("t6_rst", 3);
    check_eq("t6_miso_reset_bit", 32'(miso_a[3]), 32'd0);
    rst_n = 1'b1;
    wait_clks(20);
    check_eq("t6_no_restart", 32'(busy_a[3]), 32'd0);
    check_eq("t6_no_dv", 32'(dv_cnt[3] - d0), 32'd0);
    spi_csn[3] = 1'b1;
    wait_clks(12);
    check_eq("t6_miso_z", 32'(miso_a[3]), 32'd1);
    q_off = {}; q_off.push_back(32'h3E);
    q_mosi = {}; q_mosi.push_back(32'h81);
    run_txn(3, 1, q_off, q_mosi);

    // randomized transactions across all instances
    for (int r = 0; r < 12; r++) begin
      idx = $urandom_range(0, NI - 1);
      nw  = $urandom_range(1, 3);
      no  = $urandom_range(0, nw);
      q_off = {}; q_mosi = {};
      for (int j = 0; j < no; j++) q_off.push_back($urandom & wmask(cfg_w(idx)));
      for (int j = 0; j < nw; j++) q_mosi.push_back($urandom);
      run_txn(idx, nw, q_off, q_mosi);
    end

    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
